// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg : shared state codes, opcode/funct values and datapath encodings
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_JR        = 4'd13
  } state_t;

  typedef enum logic [2:0] {
    C_MEM_LD, C_MEM_ST, C_RTYPE, C_JR, C_ADDI, C_BR, C_JMP, C_ILL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mc_control_if.sv
// ---------------------------------------------------------------------------
// mc_control_if : control-unit <-> datapath/memory signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       link;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       retire;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
           link, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, retire,
           illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
           link, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, retire,
           illegal, state
  );
endinterface

`default_nettype wire

// File: rtl/mc_decode.sv
// ---------------------------------------------------------------------------
// mc_decode : opcode/funct -> instruction class
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output iclass_t    o_class
);

  always_comb begin
    o_class = C_ILL;
    case (i_opcode)
      OP_LW:          o_class = C_MEM_LD;
      OP_SW:          o_class = C_MEM_ST;
      OP_RTYPE:       o_class = (i_funct == FN_JR) ? C_JR : C_RTYPE;
      OP_ADDI:        o_class = C_ADDI;
      OP_BEQ, OP_BNE: o_class = C_BR;
      OP_J, OP_JAL:   o_class = C_JMP;
      default:        o_class = C_ILL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control : multi-cycle MIPS control FSM with ready-paced memory accesses
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_control
  import mips_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_control_if.master  bus
);

  state_t  r_state;
  iclass_t w_class;
  logic    w_rdy;

  mc_decode u_decode (
    .i_opcode (bus.opcode),
    .i_funct  (bus.funct),
    .o_class  (w_class)
  );

  assign w_rdy     = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign bus.state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  r_state <= w_rdy ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (w_class)
            C_MEM_LD, C_MEM_ST: r_state <= S_MEM_ADDR;
            C_RTYPE:            r_state <= S_R_EXEC;
            C_JR:               r_state <= S_JR;
            C_ADDI:             r_state <= S_ADDI_EXEC;
            C_BR:               r_state <= S_BRANCH;
            C_JMP:              r_state <= S_JUMP;
            default:            r_state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR:  r_state <= (w_class == C_MEM_ST) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:    r_state <= w_rdy ? S_MEM_WB : S_MEM_RD;
        S_MEM_WR:    r_state <= w_rdy ? S_FETCH : S_MEM_WR;
        S_R_EXEC:    r_state <= S_R_WB;
        S_ADDI_EXEC: r_state <= S_ADDI_WB;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode; the only combinational inputs used are mem ready, zero and opcode.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.link       = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_REG;
    bus.alu_op     = ALU_ADD;
    bus.pc_source  = PCSRC_ALU;
    bus.retire     = 1'b0;
    bus.illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.ir_write  = w_rdy;
        bus.pc_write  = w_rdy;
      end
      S_DECODE: begin
        bus.alu_src_b = SRCB_IMM_SH2;
        bus.illegal   = (w_class == C_ILL);
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.retire     = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        bus.retire    = w_rdy;
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
      end
      S_ADDI_WB: begin
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
      end
      S_BRANCH: begin
        // opcode[0] distinguishes bne from beq
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_SUB;
        bus.pc_source = PCSRC_ALUOUT;
        bus.pc_write  = bus.zero ^ bus.opcode[0];
        bus.retire    = 1'b1;
      end
      S_JUMP: begin
        bus.pc_source = PCSRC_JUMP;
        bus.pc_write  = 1'b1;
        bus.reg_write = (bus.opcode == OP_JAL);
        bus.link      = (bus.opcode == OP_JAL);
        bus.retire    = 1'b1;
      end
      S_JR: begin
        bus.pc_source = PCSRC_REG;
        bus.pc_write  = 1'b1;
        bus.retire    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
